// File: rtl/serial_subtractor.sv
// serial_subtractor: bit-serial diff = a - b - bin, LSB first, with a start/busy/done handshake.
// Optional macro OVERFLOW_FLAG_EN adds a registered signed-overflow output ovf.
`default_nettype none

module serial_subtractor #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             bin,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] diff,
  output logic             bout
`ifdef OVERFLOW_FLAG_EN
  ,
  output logic             ovf
`endif
);

  localparam int CNT_W = $clog2(WIDTH);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(WIDTH - 1);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } state_t;

  state_t state, state_nxt;

  logic [WIDTH-1:0] sa, sb, res;
  logic             br;
  logic [CNT_W-1:0] cnt;

  logic load, shift, finish;
  logic d_bit, br_nxt;

  // One full-subtractor cell applied to the current LSBs.
  assign d_bit  = sa[0] ^ sb[0] ^ br;
  assign br_nxt = (~sa[0] & sb[0]) | (~(sa[0] ^ sb[0]) & br);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    load      = 1'b0;
    shift     = 1'b0;
    finish    = 1'b0;
    case (state)
      IDLE: begin
        if (start) begin
          load      = 1'b1;
          state_nxt = SHIFT;
        end
      end
      SHIFT: begin
        shift = 1'b1;
        if (cnt == CNT_LAST) begin
          finish    = 1'b1;
          state_nxt = DONE;
        end
      end
      DONE:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  assign busy = (state != IDLE);
  assign done = (state == DONE);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sa   <= '0;
      sb   <= '0;
      res  <= '0;
      br   <= 1'b0;
      cnt  <= '0;
      diff <= '0;
      bout <= 1'b0;
    end else if (load) begin
      sa  <= a;
      sb  <= b;
      br  <= bin;
      cnt <= '0;
    end else if (shift) begin
      sa  <= {1'b0, sa[WIDTH-1:1]};
      sb  <= {1'b0, sb[WIDTH-1:1]};
      res <= {d_bit, res[WIDTH-1:1]};
      br  <= br_nxt;
      if (finish) begin
        // The last bit is still in flight, so the result is assembled from it directly.
        diff <= {d_bit, res[WIDTH-1:1]};
        bout <= br_nxt;
      end else begin
        cnt <= cnt + 1'b1;
      end
    end
  end

`ifdef OVERFLOW_FLAG_EN
  // Operand sign bits are shifted out of sa/sb, so keep a copy for the overflow test.
  logic a_msb, b_msb;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      a_msb <= 1'b0;
      b_msb <= 1'b0;
      ovf   <= 1'b0;
    end else if (load) begin
      a_msb <= a[WIDTH-1];
      b_msb <= b[WIDTH-1];
    end else if (finish) begin
      ovf <= (a_msb != b_msb) && (d_bit != a_msb);
    end
  end
`endif

endmodule

`default_nettype wire

// File: tb/tb_serial_subtractor.sv
// tb_serial_subtractor: randomized self-checking bench for serial_subtractor against an integer model.
`default_nettype none

module tb_serial_subtractor;

  localparam int W = 8;

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic         start = 1'b0;
  logic [W-1:0] a = '0;
  logic [W-1:0] b = '0;
  logic         bin = 1'b0;
  logic         busy, done, bout;
  logic [W-1:0] diff;
`ifdef OVERFLOW_FLAG_EN
  logic         ovf;
`endif

  int total = 0;
  int bad   = 0;

  serial_subtractor #(.WIDTH(W)) dut (
    .clk  (clk),
    .rst  (rst),
    .start(start),
    .a    (a),
    .b    (b),
    .bin  (bin),
    .busy (busy),
    .done (done),
    .diff (diff),
    .bout (bout)
`ifdef OVERFLOW_FLAG_EN
    ,
    .ovf  (ovf)
`endif
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // Reference: plain integer arithmetic on the unsigned and signed views of the operands.
  function automatic int ref_diff(input logic [W-1:0] av, bv, input logic bi);
    int r;
    r = int'(av) - int'(bv) - int'(bi);
    return r & ((1 << W) - 1);
  endfunction

  function automatic logic ref_bout(input logic [W-1:0] av, bv, input logic bi);
    return (int'(av) - int'(bv) - int'(bi)) < 0;
  endfunction

  function automatic logic ref_ovf(input logic [W-1:0] av, bv, input logic bi);
    int s;
    s = int'($signed(av)) - int'($signed(bv)) - int'(bi);
    return (s < -(1 << (W - 1))) || (s > (1 << (W - 1)) - 1);
  endfunction

  // Full operation: accept, wait for done with a bound, check latency/result, then the pulse end.
  task automatic run_op(input logic [W-1:0] av, bv, input logic bi, input string tag);
    int cyc;
    @(negedge clk);
    a = av; b = bv; bin = bi; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    a = W'($urandom); b = W'($urandom); bin = 1'($urandom);
    check({tag, "_busy"}, 32'(busy), 32'd1);
    cyc = 0;
    while (!done && cyc < 40) begin
      @(posedge clk); #1;
      cyc++;
    end
    check({tag, "_lat"}, 32'(cyc), 32'(W));
    check({tag, "_diff"}, 32'(diff), 32'(ref_diff(av, bv, bi)));
    check({tag, "_bout"}, 32'(bout), 32'(ref_bout(av, bv, bi)));
`ifdef OVERFLOW_FLAG_EN
    check({tag, "_ovf"}, 32'(ovf), 32'(ref_ovf(av, bv, bi)));
`endif
    @(posedge clk); #1;
    check({tag, "_pulse"}, 32'({busy, done}), 32'd0);
  endtask

  initial begin
    int busy_cnt, done_cnt, first_done, second_done;
    logic [W-1:0] held;

    #12;
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_done", 32'(done), 32'd0);
    check("rst_diff", 32'(diff), 32'd0);
    check("rst_bout", 32'(bout), 32'd0);
`ifdef OVERFLOW_FLAG_EN
    check("rst_ovf", 32'(ovf), 32'd0);
`endif
    @(negedge clk);
    rst = 1'b0;

    run_op(8'd100, 8'd37, 1'b0, "t1");
    run_op(8'd5,   8'd10, 1'b0, "t2a");
    run_op(8'd0,   8'd0,  1'b1, "t2b");
    run_op(8'd255, 8'd255, 1'b0, "t3a");
    run_op(8'd255, 8'd255, 1'b1, "t3b");

    // Start pulsed during SHIFT must be ignored.
    @(negedge clk);
    a = 8'd20; b = 8'd1; bin = 1'b0; start = 1'b1;
    @(posedge clk); #1;
    a = 8'd9; b = 8'd3;
    @(posedge clk); #1;
    start = 1'b0;
    busy_cnt = 0; done_cnt = 0; held = '0;
    for (int i = 0; i < 12; i++) begin
      if (busy) busy_cnt++;
      if (done) begin
        done_cnt++;
        held = diff;
      end
      @(posedge clk); #1;
    end
    check("t4_busy", 32'(busy_cnt), 32'(W));
    check("t4_done", 32'(done_cnt), 32'd1);
    check("t4_diff", 32'(held), 32'd19);

    // Asynchronous reset during the 4th shift.
    @(negedge clk);
    a = 8'd77; b = 8'd12; bin = 1'b0; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (4) @(posedge clk);
    #1;
    rst = 1'b1;
    #2;
    check("t5_busy", 32'(busy), 32'd0);
    check("t5_done", 32'(done), 32'd0);
    check("t5_diff", 32'(diff), 32'd0);
    check("t5_bout", 32'(bout), 32'd0);
    @(negedge clk);
    rst = 1'b0;
    run_op(8'd77, 8'd12, 1'b0, "t5_after");

    // Start held high re-triggers every W+2 cycles.
    @(negedge clk);
    a = 8'd200; b = 8'd55; bin = 1'b0; start = 1'b1;
    first_done = -1; second_done = -1;
    for (int i = 0; i < 40 && second_done < 0; i++) begin
      @(posedge clk); #1;
      if (done) begin
        if (first_done < 0) first_done = i;
        else second_done = i;
      end
    end
    check("hold_period", 32'(second_done - first_done), 32'(W + 2));
    check("hold_diff", 32'(diff), 32'd145);
    start = 1'b0;
    for (int i = 0; i < 20 && busy; i++) begin
      @(posedge clk); #1;
    end
    check("hold_idle", 32'(busy), 32'd0);

    for (int n = 0; n < 50; n++) begin
      run_op(W'($urandom), W'($urandom), 1'($urandom), $sformatf("rnd%0d", n));
    end

`ifdef OVERFLOW_FLAG_EN
    run_op(8'h80, 8'h01, 1'b0, "ovf1");
    check("ovf1_flag", 32'(ovf), 32'd1);
    run_op(8'h10, 8'h01, 1'b0, "ovf0");
    check("ovf0_flag", 32'(ovf), 32'd0);
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

`default_nettype wire
